// File: rtl/fmaround_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fmaround_pipe
// Brief    : Two-stage pipelined IEEE rounding unit (RNE/RZ/RN/RP) with
//            valid/ready backpressure. Optional sticky flag accumulator is
//            enabled by defining FMAROUND_ACC_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fmaround_pipe #(
    parameter int NE    = 5,
    parameter int NF    = 10,
    parameter int EXTRA = 13
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [NE+1:0]       in_exp,
    input  logic [NF+EXTRA-1:0] in_frac,
    input  logic                in_zero,
    input  logic [1:0]          roundmode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NE+NF:0]      out_result,
    output logic [2:0]          out_flags
`ifdef FMAROUND_ACC_FLAGS_EN
    ,
    input  logic                flags_clr,
    output logic [2:0]          acc_flags
`endif
);

    localparam logic [1:0] c_clsNorm  = 2'd0;
    localparam logic [1:0] c_clsZero  = 2'd1;
    localparam logic [1:0] c_clsUnder = 2'd2;
    localparam logic [1:0] c_clsOver  = 2'd3;

    localparam logic [1:0] c_modeRne = 2'd0;
    localparam logic [1:0] c_modeRz  = 2'd1;
    localparam logic [1:0] c_modeRn  = 2'd2;
    localparam logic [1:0] c_modeRp  = 2'd3;

    localparam logic [NE+1:0] c_expOvfLim = (NE+2)'((1 << NE) - 1);
    localparam logic [NE-1:0] c_expInf    = '1;
    localparam logic [NE-1:0] c_expMax    = {{(NE-1){1'b1}}, 1'b0};

    logic                w_s2Adv;
    logic                w_s1Adv;

    logic                w_guard;
    logic                w_sticky;
    logic                w_inexact;
    logic                w_inc;
    logic [1:0]          w_class;

    logic                r_s1Valid;
    logic                r_s1Sign;
    logic [NE-1:0]       r_s1Exp;
    logic [NF-1:0]       r_s1Frac;
    logic [1:0]          r_s1Mode;
    logic [1:0]          r_s1Class;
    logic                r_s1Inc;
    logic                r_s1Inexact;

    logic [NE+NF-1:0]    w_sum;
    logic                w_toInf;
    logic [NE+NF:0]      w_result;
    logic [2:0]          w_flags;

    logic                r_outValid;
    logic [NE+NF:0]      r_outResult;
    logic [2:0]          r_outFlags;

    assign w_s2Adv  = ~r_outValid | out_ready;
    assign w_s1Adv  = ~r_s1Valid | w_s2Adv;
    assign in_ready = w_s1Adv;

    assign out_valid  = r_outValid;
    assign out_result = r_outResult;
    assign out_flags  = r_outFlags;

    // Stage 1: rounding decision from L/G/S and exponent classification
    assign w_guard   = in_frac[EXTRA-1];
    assign w_sticky  = |in_frac[EXTRA-2:0];
    assign w_inexact = w_guard | w_sticky;

    always_comb begin
        w_inc = 1'b0;
        case (roundmode)
            c_modeRne: w_inc = w_guard & (in_frac[EXTRA] | w_sticky);
            c_modeRz:  w_inc = 1'b0;
            c_modeRn:  w_inc = in_sign & w_inexact;
            c_modeRp:  w_inc = ~in_sign & w_inexact;
            default:   w_inc = 1'b0;
        endcase
    end

    always_comb begin
        w_class = c_clsNorm;
        if (in_zero)
            w_class = c_clsZero;
        else if (in_exp[NE+1] || (in_exp == '0))
            w_class = c_clsUnder;
        else if (in_exp >= c_expOvfLim)
            w_class = c_clsOver;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
        end else if (w_s1Adv) begin
            r_s1Valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1Adv && in_valid) begin
            r_s1Sign    <= in_sign;
            r_s1Exp     <= in_exp[NE-1:0];
            r_s1Frac    <= in_frac[NF+EXTRA-1:EXTRA];
            r_s1Mode    <= roundmode;
            r_s1Class   <= w_class;
            r_s1Inc     <= w_inc;
            r_s1Inexact <= w_inexact;
        end
    end

    // Stage 2: one add across {exp, frac} so a fraction carry bumps the exponent
    assign w_sum = {r_s1Exp, r_s1Frac} + (NE+NF)'(r_s1Inc);

    always_comb begin
        w_toInf = 1'b1;
        case (r_s1Mode)
            c_modeRne: w_toInf = 1'b1;
            c_modeRz:  w_toInf = 1'b0;
            c_modeRn:  w_toInf = r_s1Sign;
            c_modeRp:  w_toInf = ~r_s1Sign;
            default:   w_toInf = 1'b1;
        endcase
    end

    always_comb begin
        w_result = {r_s1Sign, {(NE+NF){1'b0}}};
        w_flags  = 3'b000;
        case (r_s1Class)
            c_clsNorm: begin
                if (w_sum[NE+NF-1:NF] == c_expInf) begin
                    w_result = {r_s1Sign, c_expInf, {NF{1'b0}}};
                    w_flags  = 3'b101;
                end else begin
                    w_result = {r_s1Sign, w_sum};
                    w_flags  = {2'b00, r_s1Inexact};
                end
            end
            c_clsOver: begin
                w_flags  = 3'b101;
                w_result = w_toInf ? {r_s1Sign, c_expInf, {NF{1'b0}}}
                                   : {r_s1Sign, c_expMax, {NF{1'b1}}};
            end
            c_clsUnder: begin
                w_flags = 3'b011;
            end
            default: begin
                w_flags = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_outValid  <= 1'b0;
            r_outResult <= '0;
            r_outFlags  <= '0;
        end else if (w_s2Adv) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_outResult <= w_result;
                r_outFlags  <= w_flags;
            end
        end
    end

`ifdef FMAROUND_ACC_FLAGS_EN
    logic [2:0] r_accFlags;

    // Clear takes effect first so a same-cycle transfer is still recorded
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_accFlags <= '0;
        end else begin
            r_accFlags <= (flags_clr ? 3'b000 : r_accFlags)
                        | ((r_outValid && out_ready) ? r_outFlags : 3'b000);
        end
    end

    assign acc_flags = r_accFlags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmaround_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmaround_pipe
// Brief    : Scoreboard bench for fmaround_pipe with an arithmetic rounding model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmaround_pipe;

    localparam int NE    = 5;
    localparam int NF    = 10;
    localparam int EXTRA = 13;

    typedef struct {
        bit          s;
        int          e;
        int unsigned f;
        bit          z;
        int          m;
    } beat_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                in_sign = 1'b0;
    logic [NE+1:0]       in_exp = '0;
    logic [NF+EXTRA-1:0] in_frac = '0;
    logic                in_zero = 1'b0;
    logic [1:0]          roundmode = 2'b00;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [NE+NF:0]      out_result;
    logic [2:0]          out_flags;
`ifdef FMAROUND_ACC_FLAGS_EN
    logic                flags_clr = 1'b0;
    logic [2:0]          acc_flags;
`endif

    int checks = 0;
    int errors = 0;
    int nAcc   = 0;
    logic [18:0] sb[$];

    fmaround_pipe #(.NE(NE), .NF(NF), .EXTRA(EXTRA)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_frac    (in_frac),
        .in_zero    (in_zero),
        .roundmode  (roundmode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
`ifdef FMAROUND_ACC_FLAGS_EN
        ,
        .flags_clr  (flags_clr),
        .acc_flags  (acc_flags)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    // Reference: round by comparing the discarded remainder against one half ULP
    function automatic logic [18:0] model(beat_t b);
        int unsigned kept, rem, half;
        int mag;
        bit up;
        int cInf = 31 * 1024;
        int cMax = 30 * 1024 + 1023;
        if (b.z) return {b.s, 15'd0, 3'b000};
        if (b.e <= 0) return {b.s, 15'd0, 3'b011};
        if (b.e >= 31) begin
            case (b.m)
                0:       mag = cInf;
                1:       mag = cMax;
                2:       mag = b.s ? cInf : cMax;
                default: mag = b.s ? cMax : cInf;
            endcase
            return {b.s, 15'(mag), 3'b101};
        end
        kept = b.f >> EXTRA;
        rem  = b.f & ((1 << EXTRA) - 1);
        half = 1 << (EXTRA - 1);
        case (b.m)
            0:       up = (rem > half) || (rem == half && kept % 2 == 1);
            1:       up = 1'b0;
            2:       up = b.s && rem != 0;
            default: up = !b.s && rem != 0;
        endcase
        mag = b.e * 1024 + int'(kept) + int'(up);
        if (mag >= cInf) return {b.s, 15'(cInf), 3'b101};
        return {b.s, 15'(mag), 2'b00, rem != 0};
    endfunction

    function automatic beat_t mk(bit s, int e, int unsigned f, bit z, int m);
        beat_t b;
        b.s = s; b.e = e; b.f = f; b.z = z; b.m = m;
        return b;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic sendBeat(beat_t b, logic [18:0] expv);
        in_sign   = b.s;
        in_exp    = (NE+2)'(b.e);
        in_frac   = (NF+EXTRA)'(b.f);
        in_zero   = b.z;
        roundmode = 2'(b.m);
        in_valid  = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(expv);
                nAcc++;
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=0 required in_ready=1");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 1000; k++) begin
            if (sb.size() == 0 && !out_valid) return;
            idle(1);
        end
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
    endtask

    // Monitor: pops on each output transfer and checks hold stability under stall
    logic        holdValid = 1'b0;
    logic [18:0] heldVal;
    always @(negedge clk) begin
        logic [18:0] want;
        if (!reset_n) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid) begin
                checks++;
                if (!out_valid || {out_result, out_flags} !== heldVal) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b %h required v=1 %h",
                             out_valid, {out_result, out_flags}, heldVal);
                end
            end
            holdValid = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h required none",
                                 {out_result, out_flags});
                    end else begin
                        want = sb.pop_front();
                        if ({out_result, out_flags} !== want) begin
                            errors++;
                            $display("FAIL result: got res=%h flags=%b required res=%h flags=%b",
                                     out_result, out_flags, want[18:3], want[2:0]);
                        end
                    end
                end else begin
                    holdValid = 1'b1;
                    heldVal   = {out_result, out_flags};
                end
            end
        end
    end

    initial begin
        beat_t b;
        int    base;
        bit    done;

        idle(3);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk); #1;

        // RNE tie-to-even carrying into the exponent, with latency check
        sendBeat(mk(0, 15, 'h7FF000, 0, 0), {16'h4000, 3'b001});
        @(negedge clk);
        check("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        drain();

        sendBeat(mk(1, 15, 'h003000, 0, 1), {16'hBC01, 3'b001});
        sendBeat(mk(1, 15, 'h003000, 0, 2), {16'hBC02, 3'b001});
        sendBeat(mk(0, 31, 0, 0, 0), {16'h7C00, 3'b101});
        sendBeat(mk(0, 31, 0, 0, 1), {16'h7BFF, 3'b101});
        sendBeat(mk(1, 31, 0, 0, 2), {16'hFC00, 3'b101});
        sendBeat(mk(1, 31, 0, 0, 3), {16'hFBFF, 3'b101});
        sendBeat(mk(1, 0, 'h12345, 0, 0), {16'h8000, 3'b011});
        sendBeat(mk(0, 15, 'h5A5A5A, 1, 3), {16'h0000, 3'b000});
        drain();

        // Backpressure: 4 back-to-back beats while the output is stalled
        out_ready = 1'b0;
        base = nAcc;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    b = mk(i[0], 10 + i, $urandom & 32'h7FFFFF, 0, i);
                    sendBeat(b, model(b));
                end
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_accepted", 32'(nAcc - base), 32'd2);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        b = mk(0, 20, 'h100000, 0, 0);
        sendBeat(b, model(b));
        b = mk(1, 21, 'h200000, 0, 1);
        sendBeat(b, model(b));
        reset_n = 1'b0;
        sb.delete();
        idle(1);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_result", 32'(out_result), 32'd0);
`ifdef FMAROUND_ACC_FLAGS_EN
        check("acc_after_reset", 32'(acc_flags), 32'd0);
`endif
        @(posedge clk); #1;
        sendBeat(mk(0, 31, 0, 0, 0), {16'h7C00, 3'b101});
        drain();
`ifdef FMAROUND_ACC_FLAGS_EN
        check("acc_overflow", 32'(acc_flags), 32'd5);
        flags_clr = 1'b1;
        idle(1);
        flags_clr = 1'b0;
        check("acc_cleared", 32'(acc_flags), 32'd0);
`endif

        // Randomised traffic with random output stalls
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    b.s = 1'($urandom);
                    b.e = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 30))
                                                      : int'($urandom_range(0, 40)) - 4;
                    b.f = $urandom & 32'h7FFFFF;
                    if ($urandom_range(0, 3) == 0) b.f = b.f | 32'h7FE000;
                    b.z = ($urandom_range(0, 15) == 0);
                    b.m = int'($urandom_range(0, 3));
                    if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
                    sendBeat(b, model(b));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
